// File: rtl/dallanma_cozucu.sv
// dallanma_cozucu: in-order branch resolution, predictor update, fetch redirect and perf counters
module dallanma_cozucu #(
    parameter int KUYRUK_DERINLIK = 4,
    parameter int SAYAC_BIT = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 getir_gecerli,
    input  logic [31:0]          getir_ps,
    input  logic                 getir_tahmin_dallan,
    input  logic [31:0]          getir_tahmin_ps,
    output logic                 getir_hazir,
    input  logic                 yurut_gecerli,
    input  logic [31:0]          yurut_ps,
    input  logic                 yurut_dallan,
    input  logic [31:0]          yurut_dallan_ps,
    output logic                 guncelle_gecerli,
    output logic [31:0]          guncelle_ps,
    output logic                 guncelle_dallan,
    output logic [31:0]          guncelle_dallan_ps,
    output logic                 yonlendir,
    output logic [31:0]          yonlendir_ps,
    output logic [SAYAC_BIT-1:0] dallan_sayaci,
    output logic [SAYAC_BIT-1:0] hata_sayaci,
    output logic                 sira_hatasi
);
    localparam int AW = $clog2(KUYRUK_DERINLIK);

    logic [31:0]          ps_mem [KUYRUK_DERINLIK];
    logic                 td_mem [KUYRUK_DERINLIK];
    logic [31:0]          tp_mem [KUYRUK_DERINLIK];
    logic [AW:0]          wp_q, wp_d, rp_q, rp_d;
    logic                 gg_q, gd_q, y_q, err_q, err_d;
    logic [31:0]          gps_q, gdps_q, yps_q, yps_d;
    logic [SAYAC_BIT-1:0] dc_q, dc_d, hc_q, hc_d;
    logic                 bos, dolu, it, sira_bozuk, hata;
    logic [31:0]          dogru_ps;

    assign bos        = wp_q == rp_q;
    assign dolu       = (wp_q[AW-1:0] == rp_q[AW-1:0]) && (wp_q[AW] != rp_q[AW]);
    assign it         = getir_gecerli && !dolu;
    assign dogru_ps   = yurut_dallan ? yurut_dallan_ps : yurut_ps + 32'd4;
    assign sira_bozuk = bos || ps_mem[rp_q[AW-1:0]] != yurut_ps;
    assign hata       = sira_bozuk || tp_mem[rp_q[AW-1:0]] != dogru_ps;

    always_comb begin
        wp_d  = wp_q + (AW+1)'(it);
        rp_d  = !yurut_gecerli ? rp_q : hata ? wp_d : rp_q + (AW+1)'(1);
        yps_d = yurut_gecerli && hata ? dogru_ps : yps_q;
        err_d = err_q || (yurut_gecerli && sira_bozuk);
        dc_d  = dc_q + SAYAC_BIT'(yurut_gecerli && dc_q != '1);
        hc_d  = hc_q + SAYAC_BIT'(yurut_gecerli && hata && hc_q != '1);
    end

    always_ff @(posedge clk)
        if (it) begin
            ps_mem[wp_q[AW-1:0]] <= getir_ps;
            td_mem[wp_q[AW-1:0]] <= getir_tahmin_dallan;
            tp_mem[wp_q[AW-1:0]] <= getir_tahmin_ps;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp_q   <= '0;
            rp_q   <= '0;
            gg_q   <= 1'b0;
            gps_q  <= '0;
            gd_q   <= 1'b0;
            gdps_q <= '0;
            y_q    <= 1'b0;
            yps_q  <= '0;
            dc_q   <= '0;
            hc_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            wp_q   <= wp_d;
            rp_q   <= rp_d;
            gg_q   <= yurut_gecerli;
            gps_q  <= yurut_gecerli ? yurut_ps : gps_q;
            gd_q   <= yurut_gecerli ? yurut_dallan : gd_q;
            gdps_q <= yurut_gecerli ? yurut_dallan_ps : gdps_q;
            y_q    <= yurut_gecerli && hata;
            yps_q  <= yps_d;
            dc_q   <= dc_d;
            hc_q   <= hc_d;
            err_q  <= err_d;
        end

    assign getir_hazir        = !dolu;
    assign guncelle_gecerli   = gg_q;
    assign guncelle_ps        = gps_q;
    assign guncelle_dallan    = gd_q;
    assign guncelle_dallan_ps = gdps_q;
    assign yonlendir          = y_q;
    assign yonlendir_ps       = yps_q;
    assign dallan_sayaci      = dc_q;
    assign hata_sayaci        = hc_q;
    assign sira_hatasi        = err_q;

    logic unused_td;
    assign unused_td = td_mem[0];
endmodule

// File: doc/dallanma_cozucu.md
Name: dallanma_cozucu

Overview:
- Execute-side branch resolution unit, at the opposite end of the gshare predictor's update interface.
- Records each prediction issued at fetch in an in-order in-flight queue.
- When execute resolves a branch, compares the actual next PC with the predicted next PC. Drives the predictor update port, the fetch redirect/flush, and performance counters.

Parameters:
- KUYRUK_DERINLIK, 4: in-flight queue depth. Power of 2, minimum 2.
- SAYAC_BIT, 32: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- getir_gecerli  in  1  fetch issues a conditional branch with a prediction this cycle.
- getir_ps  in  32  PC of that branch.
- getir_tahmin_dallan  in  1  predicted taken.
- getir_tahmin_ps  in  32  predicted next PC: target if taken, getir_ps+4 otherwise.
- getir_hazir  out  1  queue can accept a push. Fetch stalls when low.
- yurut_gecerli  in  1  execute resolves the oldest in-flight branch this cycle.
- yurut_ps  in  32  PC of the resolved branch.
- yurut_dallan  in  1  actual direction.
- yurut_dallan_ps  in  32  actual target. Meaningful only when yurut_dallan=1.
- guncelle_gecerli  out  1  one-cycle update strobe to the predictor.
- guncelle_ps  out  32  update PC.
- guncelle_dallan  out  1  update direction.
- guncelle_dallan_ps  out  32  update target.
- yonlendir  out  1  one-cycle misprediction redirect/flush pulse to fetch.
- yonlendir_ps  out  32  correct next PC.
- dallan_sayaci  out  SAYAC_BIT  resolved branches.
- hata_sayaci  out  SAYAC_BIT  mispredictions.
- sira_hatasi  out  1  sticky protocol-error flag.

Behaviour:
- Reset: rst asynchronous, active-high.
  - Queue empty, pointers 0.
  - All registered outputs 0: guncelle_*, yonlendir, yonlendir_ps, counters, sira_hatasi.
  - getir_hazir is 1 during and after reset.
  - Reset mid-operation discards all in-flight entries.
- Queue storage: each entry holds {ps, tahmin_dallan, tahmin_ps}.
- Queue pointers: read and write pointers are log2(KUYRUK_DERINLIK)+1 bits, wrap naturally. Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
- getir_hazir = !full, combinational. It does not depend on a same-cycle pop.
- Push: getir_gecerli && getir_hazir writes the tail entry. getir_gecerli while full is dropped, with no other effect.
- Resolve, on the cycle with yurut_gecerli=1:
  - dogru_ps = yurut_dallan ? yurut_dallan_ps : yurut_ps+4, modulo 2^32.
  - Misprediction = queue empty, OR head.ps != yurut_ps, OR head.tahmin_ps != dogru_ps.
  - Next-PC compare only: a taken branch whose target equals ps+4 is not a misprediction.
- Output timing, registered with 1-cycle latency after the yurut_gecerli edge:
  - guncelle_gecerli=1 for exactly one cycle.
  - guncelle_ps=yurut_ps, guncelle_dallan=yurut_dallan, guncelle_dallan_ps=yurut_dallan_ps.
  - Data outputs hold their value when the strobe is low.
- On misprediction:
  - yonlendir=1 for one cycle, coincident with guncelle_gecerli.
  - yonlendir_ps=dogru_ps.
  - Entire queue flushed (read pointer set to write pointer), including any push in the same cycle. That push is wrong-path and is discarded.
- Correct prediction: head popped. A simultaneous push is accepted if getir_hazir was high; occupancy is unchanged.
- Queue empty or PC mismatch: sira_hatasi set to 1, sticky, cleared only by rst. Still counted as a misprediction and redirected.
- Counters:
  - dallan_sayaci +1 per resolve.
  - hata_sayaci +1 per misprediction.
  - Both saturate at 2^SAYAC_BIT-1 with no wrap.
  - Update in the same edge as guncelle_gecerli.
- Back-to-back resolves on consecutive cycles are supported. After a redirect, the next resolve sees an empty queue unless fetch has pushed new entries.

Test Plan:
- Reset, then push {ps=0x100, tahmin=1, tahmin_ps=0x140}; resolve ps=0x100, dallan=1, target=0x140 -> next cycle guncelle_gecerli=1, guncelle_ps=0x100, yonlendir=0, dallan_sayaci=1, hata_sayaci=0, queue empty.
- Push {0x200, tahmin=1, tahmin_ps=0x180}; resolve 0x200, dallan=0 -> yonlendir=1, yonlendir_ps=0x204, hata_sayaci=1, queue empty.
- Push 4 entries, getir_hazir=0. A fifth push is dropped. Resolving all 4 correctly pops in order and getir_hazir returns to 1.
- Queue holds 2 entries. Mispredicted resolve of the head with a simultaneous push -> queue empty afterwards and the pushed entry is discarded.
- Resolve with empty queue -> sira_hatasi=1, yonlendir=1. The flag stays 1 through later correct resolves until rst.
- Assert rst with 3 entries queued mid-stream -> all outputs 0 immediately, getir_hazir=1. SAYAC_BIT=2: 5 mispredictions -> hata_sayaci saturates at 3.
